// File: rtl/multichannel_sampler.sv
// Multi-channel pulse sampler: keeps a rolling WINDOW-deep history per channel and
// freezes a pre/post-trigger snapshot for the event writer via a ready/saved handshake.
module multichannel_sampler #(
  parameter int N_CH      = 32,
  parameter int WINDOW    = 80,
  parameter int PRE_TRIG  = 20,
  parameter int HOLDOFF   = 4,
  parameter int TRIG_MODE = 0,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          ch_in,
  input  logic                     trig_tresh,
  input  logic [N_CH-1:0]          trig_mask,
  input  logic                     event_saved,
  output logic                     event_ready,
  output logic [N_CH*WINDOW-1:0]   evento,
  output logic                     armed,
  output logic [CNT_W-1:0]         event_cnt,
  output logic [CNT_W-1:0]         missed_cnt
);

  localparam int CW = $clog2(WINDOW);
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [CW-1:0] FILL_MAX  = CW'(WINDOW - 1);
  localparam logic [CW-1:0] POST_LOAD = CW'(WINDOW - PRE_TRIG - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_POST, S_READY, S_HOLD} state_t;

  state_t state, next_state;

  logic [N_CH*WINDOW-1:0] hist;
  logic [N_CH-1:0]        ch_prev;
  logic                   trig_prev;
  logic [CW-1:0]          fill_cnt;
  logic [CW-1:0]          post_cnt;
  logic [HW-1:0]          hold_cnt;

  logic filled, ext_trig, self_trig, trig, missed;
  logic load_post, capture, handshake, load_hold;

  assign ext_trig  = trig_tresh & ~trig_prev;
  assign self_trig = |(trig_mask & ch_in & ~ch_prev);
  assign trig      = (TRIG_MODE == 1) ? self_trig : ext_trig;
  assign filled    = (fill_cnt == FILL_MAX);
  assign missed    = trig && (state != S_IDLE);

  assign event_ready = (state == S_READY);
  assign armed       = (state == S_IDLE) && filled;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_prev <= 1'b0;
      ch_prev   <= '0;
      fill_cnt  <= '0;
    end else begin
      trig_prev <= trig_tresh;
      ch_prev   <= ch_in;
      if (!filled)
        fill_cnt <= fill_cnt + 1'b1;
    end
  end

  // Newest sample enters at the top of each channel field, so bit 0 is always the oldest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++)
        hist[c*WINDOW +: WINDOW] <= {ch_in[c], hist[c*WINDOW+1 +: WINDOW-1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_post  = 1'b0;
    capture    = 1'b0;
    handshake  = 1'b0;
    load_hold  = 1'b0;
    case (state)
      S_IDLE:
        if (trig && filled) begin
          next_state = S_POST;
          load_post  = 1'b1;
        end
      S_POST:
        if (post_cnt == '0) begin
          next_state = S_READY;
          capture    = 1'b1;
        end
      S_READY:
        if (event_saved) begin
          handshake = 1'b1;
          if (HOLDOFF == 0) begin
            next_state = S_IDLE;
          end else begin
            next_state = S_HOLD;
            load_hold  = 1'b1;
          end
        end
      S_HOLD:
        if (hold_cnt == '0)
          next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // The history register already holds samples T-PRE_TRIG .. T+WINDOW-PRE_TRIG-1 at capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_cnt   <= '0;
      hold_cnt   <= '0;
      evento     <= '0;
      event_cnt  <= '0;
      missed_cnt <= '0;
    end else begin
      if (load_post)
        post_cnt <= POST_LOAD;
      else if (state == S_POST && post_cnt != '0)
        post_cnt <= post_cnt - 1'b1;

      if (load_hold)
        hold_cnt <= HOLD_LOAD;
      else if (state == S_HOLD && hold_cnt != '0)
        hold_cnt <= hold_cnt - 1'b1;

      if (capture)
        evento <= hist;

      if (handshake)
        event_cnt <= event_cnt + 1'b1;

      if (missed && missed_cnt != '1)
        missed_cnt <= missed_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_multichannel_sampler.sv
// Scoreboard bench for multichannel_sampler: one instance per trigger mode, expected
// snapshots queued at trigger time and checked by monitors when event_ready rises.
module tb_multichannel_sampler;

  localparam int N_CH   = 32;
  localparam int WINDOW = 80;
  localparam int W      = N_CH * WINDOW;
  localparam int CNT_W  = 16;

  typedef struct {
    logic [W-1:0] ev;
    int           at;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [N_CH-1:0]  ch_in       = '0;
  logic             trig_tresh  = 1'b0;
  logic [N_CH-1:0]  trig_mask0  = '0;
  logic             event_saved = 1'b0;
  logic             event_ready;
  logic [W-1:0]     evento;
  logic             armed;
  logic [CNT_W-1:0] event_cnt;
  logic [CNT_W-1:0] missed_cnt;

  logic [N_CH-1:0]  ch1     = '0;
  logic             trig1   = 1'b0;
  logic [N_CH-1:0]  mask1   = 32'h1;
  logic             saved1  = 1'b0;
  logic             ready1;
  logic [W-1:0]     evento1;
  logic             armed1;
  logic [CNT_W-1:0] event_cnt1;
  logic [CNT_W-1:0] missed_cnt1;

  int edge_n;
  int checks = 0;
  int errors = 0;

  multichannel_sampler #(.TRIG_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .ch_in(ch_in), .trig_tresh(trig_tresh), .trig_mask(trig_mask0),
    .event_saved(event_saved), .event_ready(event_ready), .evento(evento), .armed(armed),
    .event_cnt(event_cnt), .missed_cnt(missed_cnt)
  );

  multichannel_sampler #(.TRIG_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .ch_in(ch1), .trig_tresh(trig1), .trig_mask(mask1),
    .event_saved(saved1), .event_ready(ready1), .evento(evento1), .armed(armed1),
    .event_cnt(event_cnt1), .missed_cnt(missed_cnt1)
  );

  always #5 clk = ~clk;

  // Edge numbering restarts at each reset; edge 1 is the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, actual, expected, edge_n);
    end
  endtask

  task automatic checkEvento(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    int first;
    checks++;
    if (actual !== expected) begin
      errors++;
      first = -1;
      for (int i = W - 1; i >= 0; i--)
        if (actual[i] !== expected[i]) first = i;
      $display("[TB] FAIL %s: lowest differing bit %0d got %b expected %b", name, first,
               actual[first], expected[first]);
    end
  endtask

  // Leaves the caller 1 time unit after edge at-1, so new inputs are sampled at edge 'at'.
  task automatic advanceTo(input int at);
    while (edge_n < at - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int at, input logic [N_CH-1:0] ch, input logic tr, input logic sv);
    advanceTo(at);
    ch_in       = ch;
    trig_tresh  = tr;
    event_saved = sv;
  endtask

  initial begin : monitor0
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (event_ready && !prev) begin
          if (q0.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL dut0 unexpected event: got event_ready=1 expected 0 at edge %0d", edge_n);
          end else begin
            e = q0.pop_front();
            checkOutput("dut0 ready edge", edge_n, e.at);
            checkEvento("dut0 snapshot", evento, e.ev);
          end
        end
        prev = event_ready;
      end
    end
  end

  initial begin : monitor1
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (ready1 && !prev) begin
          if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL dut1 unexpected event: got event_ready=1 expected 0 at edge %0d", edge_n);
          end else begin
            e = q1.pop_front();
            checkOutput("dut1 ready edge", edge_n, e.at);
            checkEvento("dut1 snapshot", evento1, e.ev);
          end
        end
        prev = ready1;
      end
    end
  end

  initial begin : stimulus
    logic [W-1:0] e;
    logic [W-1:0] exp_d;

    @(posedge clk); #1;
    checkOutput("reset event_ready", event_ready, 0);
    checkOutput("reset armed", armed, 0);
    checkOutput("reset event_cnt", event_cnt, 0);
    checkOutput("reset missed_cnt", missed_cnt, 0);
    checkEvento("reset evento", evento, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Trigger during fill is ignored and not counted
    applyStimulus(10, '0, 1'b1, 1'b0);
    applyStimulus(11, '0, 1'b0, 1'b0);
    checkOutput("fill trig armed", armed, 0);
    checkOutput("fill trig missed", missed_cnt, 0);
    advanceTo(79);
    checkOutput("armed before 79", armed, 0);
    advanceTo(80);
    checkOutput("armed at 79", armed, 1);

    // Walking one on channel 3, external trigger at edge 110
    applyStimulus(100, 32'h8, 1'b0, 1'b0);
    applyStimulus(101, '0, 1'b0, 1'b0);
    applyStimulus(110, '0, 1'b1, 1'b0);
    e = '0; e[3*80+10] = 1'b1;
    q0.push_back('{ev: e, at: 170});
    applyStimulus(111, '0, 1'b0, 1'b0);
    advanceTo(170);
    checkOutput("ready before latency", event_ready, 0);
    advanceTo(171);
    checkOutput("ready at latency", event_ready, 1);
    applyStimulus(175, '0, 1'b0, 1'b1);
    applyStimulus(176, '0, 1'b0, 1'b0);
    checkOutput("ready drop after saved", event_ready, 0);
    checkOutput("event_cnt after 1st", event_cnt, 1);
    checkOutput("missed after 1st", missed_cnt, 0);

    // Held trigger level; window boundaries probed at 179/180 and 259/260
    applyStimulus(179, 32'h40, 1'b0, 1'b0);
    applyStimulus(180, 32'h20, 1'b0, 1'b0);
    applyStimulus(181, '0, 1'b0, 1'b0);
    applyStimulus(200, 32'h8000_0000, 1'b1, 1'b0);
    e = '0; e[31*80+20] = 1'b1; e[0*80+79] = 1'b1; e[5*80+0] = 1'b1;
    q0.push_back('{ev: e, at: 260});
    applyStimulus(201, '0, 1'b1, 1'b0);
    applyStimulus(259, 32'h1, 1'b1, 1'b0);
    applyStimulus(260, 32'h80, 1'b1, 1'b0);
    applyStimulus(261, '0, 1'b1, 1'b0);
    applyStimulus(265, '0, 1'b1, 1'b1);
    applyStimulus(266, '0, 1'b1, 1'b0);
    checkOutput("held trig ready drop", event_ready, 0);
    checkOutput("held trig event_cnt", event_cnt, 2);
    applyStimulus(400, '0, 1'b0, 1'b0);
    advanceTo(402);
    checkOutput("held trig single event", event_cnt, 2);
    checkOutput("held trig missed", missed_cnt, 0);

    // Extra triggers in POST and READY are missed and leave the capture alone
    applyStimulus(420, '0, 1'b1, 1'b0);
    exp_d = '0; exp_d[10*80+30] = 1'b1; exp_d[12*80+55] = 1'b1;
    q0.push_back('{ev: exp_d, at: 480});
    applyStimulus(421, '0, 1'b0, 1'b0);
    applyStimulus(430, 32'h400, 1'b0, 1'b0);
    applyStimulus(431, '0, 1'b0, 1'b0);
    applyStimulus(450, '0, 1'b1, 1'b0);
    applyStimulus(451, '0, 1'b0, 1'b0);
    checkOutput("missed in POST", missed_cnt, 1);
    applyStimulus(455, 32'h1000, 1'b0, 1'b0);
    applyStimulus(456, '0, 1'b0, 1'b0);
    applyStimulus(490, '0, 1'b1, 1'b0);
    applyStimulus(491, '0, 1'b0, 1'b0);
    checkOutput("missed in READY", missed_cnt, 2);
    checkOutput("ready held", event_ready, 1);
    advanceTo(496);
    checkEvento("snapshot unchanged", evento, exp_d);
    applyStimulus(500, '0, 1'b0, 1'b1);
    applyStimulus(501, '0, 1'b0, 1'b0);
    checkOutput("event_cnt 3rd", event_cnt, 3);
    checkOutput("missed after 3rd", missed_cnt, 2);
    applyStimulus(504, '0, 1'b1, 1'b0);
    applyStimulus(505, '0, 1'b0, 1'b0);
    checkOutput("missed on holdoff exit", missed_cnt, 3);
    checkOutput("armed after holdoff", armed, 1);
    applyStimulus(506, 32'h10_0000, 1'b1, 1'b0);
    e = '0; e[20*80+20] = 1'b1;
    q0.push_back('{ev: e, at: 566});
    applyStimulus(507, '0, 1'b0, 1'b0);
    checkOutput("armed drops on accept", armed, 0);
    applyStimulus(530, '0, 1'b0, 1'b1);
    applyStimulus(531, '0, 1'b0, 1'b0);
    checkOutput("saved ignored in POST", event_cnt, 3);
    advanceTo(567);
    checkOutput("4th ready", event_ready, 1);
    applyStimulus(570, '0, 1'b1, 1'b1);
    applyStimulus(571, '0, 1'b0, 1'b0);
    checkOutput("event_cnt 4th", event_cnt, 4);
    checkOutput("missed on ready exit", missed_cnt, 4);
    checkOutput("ready drop 4th", event_ready, 0);

    // Asynchronous reset while in POST aborts the capture
    applyStimulus(600, '0, 1'b1, 1'b0);
    applyStimulus(601, '0, 1'b0, 1'b0);
    advanceTo(620);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async rst event_cnt", event_cnt, 0);
    checkOutput("async rst missed_cnt", missed_cnt, 0);
    checkOutput("async rst armed", armed, 0);
    checkOutput("async rst ready", event_ready, 0);
    checkEvento("async rst evento", evento, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus(50, '0, 1'b1, 1'b0);
    applyStimulus(51, '0, 1'b0, 1'b0);
    checkOutput("refill trig missed", missed_cnt, 0);
    checkOutput("refill armed", armed, 0);
    applyStimulus(95, 32'h2, 1'b0, 1'b0);
    applyStimulus(96, '0, 1'b0, 1'b0);
    applyStimulus(100, '0, 1'b1, 1'b0);
    e = '0; e[1*80+15] = 1'b1;
    q0.push_back('{ev: e, at: 160});
    applyStimulus(101, '0, 1'b0, 1'b0);
    applyStimulus(165, '0, 1'b0, 1'b1);
    applyStimulus(166, '0, 1'b0, 1'b0);
    checkOutput("after refill event_cnt", event_cnt, 1);
    checkOutput("after refill missed", missed_cnt, 0);

    // Self-trigger: masked-out channel 1 must not fire, channel 0 must
    advanceTo(200);
    ch1 = 32'h2;
    advanceTo(205);
    ch1 = '0;
    advanceTo(220);
    ch1 = 32'h1;
    e = '0;
    for (int k = 0; k < 5; k++) e[80+k] = 1'b1;
    for (int k = 20; k < 23; k++) e[k] = 1'b1;
    q1.push_back('{ev: e, at: 280});
    advanceTo(223);
    ch1 = '0;
    advanceTo(261);
    checkOutput("self trig mask ignored", ready1, 0);
    checkOutput("self trig missed", missed_cnt1, 0);
    advanceTo(281);
    checkOutput("self trig ready", ready1, 1);
    advanceTo(285);
    saved1 = 1'b1;
    advanceTo(286);
    saved1 = 1'b0;
    checkOutput("self trig event_cnt", event_cnt1, 1);

    advanceTo(300);
    checkOutput("dut0 events all seen", q0.size(), 0);
    checkOutput("dut1 events all seen", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
